// File: rtl/sha3_pad_absorb_buffer.sv
// sha3_pad_absorb_buffer: packs 64-bit message words into rate lanes, applies pad10*1 with
// the domain byte, and emits zero-capacity 1600-bit blocks for absorption.
module sha3_pad_absorb_buffer #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_nbytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1599:0] out_block,
  output logic          out_last
);
  typedef enum logic {FILL, EMIT} state_t;
  localparam int         TOP_BIT   = 64 * RATE_LANES - 1;
  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
  state_t          r_state, w_state_next;
  logic [4:0]      r_cnt;
  logic [1599:0]   r_block;
  logic            r_last, r_pad_pending;
  logic [3:0]      w_nb;
  logic [63:0]     w_word;
  logic [1599:0]   w_fill, w_pad;
  logic            w_at_end, w_full_last, w_accept, w_done;
  assign in_ready  = r_state == FILL;
  assign out_valid = r_state == EMIT;
  assign out_block = r_block;
  assign out_last  = r_last;
  always_comb begin
    w_nb        = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    w_at_end    = r_cnt == LAST_LANE;
    w_full_last = in_last && w_nb == 4'd8;
    w_accept    = in_valid && in_ready;
    w_done      = in_last || w_at_end;
    // bytes past the message end are zeroed; the first one carries the domain byte
    for (int k = 0; k < 8; k++)
      w_word[8*k +: 8] = (!in_last || 4'(k) < w_nb) ? in_data[8*k +: 8] :
                         (4'(k) == w_nb) ? DOMAIN : 8'h00;
    w_fill = r_block;
    w_fill[{r_cnt, 6'd0} +: 64] = w_word;
    w_fill[TOP_BIT] = w_fill[TOP_BIT] | (in_last && !(w_full_last && w_at_end));
    if (w_full_last && !w_at_end)
      w_fill[{5'(r_cnt + 5'd1), 6'd0} +: 8] = w_fill[{5'(r_cnt + 5'd1), 6'd0} +: 8] | DOMAIN;
    w_pad = '0;
    w_pad[7:0] = DOMAIN;
    w_pad[TOP_BIT] = 1'b1;
    w_state_next = r_state;
    if (r_state == FILL && w_accept && w_done) w_state_next = EMIT;
    if (r_state == EMIT && out_ready && !r_pad_pending) w_state_next = FILL;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_block       <= '0;
      r_last        <= 1'b0;
      r_pad_pending <= 1'b0;
    end else if (r_state == FILL) begin
      if (w_accept) begin
        r_block       <= w_fill;
        r_cnt         <= w_done ? r_cnt : r_cnt + 5'd1;
        r_last        <= in_last && !(w_full_last && w_at_end);
        r_pad_pending <= w_full_last && w_at_end;
      end
    end else if (out_ready) begin
      // a message ending exactly on a block boundary needs a trailing pad-only block
      r_cnt         <= '0;
      r_block       <= r_pad_pending ? w_pad : '0;
      r_last        <= r_pad_pending;
      r_pad_pending <= 1'b0;
    end
  end
endmodule
